floor_addr_gen: RTL and testbench



---
 rtl/floor_pkg.sv | 10 +
 rtl/tile_wrap_counter.sv | 34 +++
 rtl/floor_addr_gen.sv | 107 ++++++++++
 tb/tb_floor_addr_gen.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/floor_pkg.sv
// Shared constants and types for the floor tile path.
package floor_pkg;
  localparam int TILE_W          = 20;
  localparam int TILE_H          = 20;
  localparam int SCROLL_STEP_DEF = 1;
  localparam int RGB_W           = 12;
  localparam int FLOOR_ROM_SIZE  = TILE_W * TILE_H;

  typedef logic [RGB_W-1:0] rgb_t;
endpackage

// File: rtl/tile_wrap_counter.sv
// Modulo-MOD counter with synchronous load (priority) and increment.
// cnt_next exposes the value the counter takes at the next edge so the
// caller can build an address from it in the same cycle.
module tile_wrap_counter #(
  parameter int MOD = 20,
  localparam int W  = (MOD > 1) ? $clog2(MOD) : 1
)(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_next
);
  logic [W-1:0] r_cnt;
  logic         w_wrap;

  assign w_wrap = (r_cnt == W'(MOD - 1));
  assign cnt    = r_cnt;

  // Next value: load beats increment, increment wraps at MOD-1.
  always_comb begin
    cnt_next = r_cnt;
    if (load)     cnt_next = load_val;
    else if (inc) cnt_next = w_wrap ? '0 : r_cnt + 1'b1;
  end

  // Counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cnt <= '0;
    else       r_cnt <= cnt_next;
  end
endmodule

// File: rtl/floor_addr_gen.sv
// Raster position -> floor tile ROM address, with per-frame horizontal
// scroll, plus re-timing of ROM data and visibility into rgb_o/rgb_valid.
// Latency: pixel_tick in cycle T -> rgb_valid in cycle T+3.
module floor_addr_gen #(
  parameter int DATA_WIDTH  = floor_pkg::RGB_W,
  parameter int ADDR_WIDTH  = 20,
  parameter int TILE_W      = floor_pkg::TILE_W,
  parameter int TILE_H      = floor_pkg::TILE_H,
  parameter int SCROLL_STEP = floor_pkg::SCROLL_STEP_DEF
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pixel_tick,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  input  logic                  video_on,
  input  logic                  frame_start,
  input  logic                  scroll_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] rgb_o,
  output logic                  rgb_valid
);
  localparam int UW  = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int VW  = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int UW1 = UW + 1;

  logic [UW-1:0]         r_scroll_u;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic                  r_vis_d1;
  logic [1:0]            r_vld_pipe;
  logic [DATA_WIDTH-1:0] r_rgb;
  logic                  r_rgb_valid;

  logic                  w_line_start, w_frame_top;
  logic [UW-1:0]         w_u_cnt, w_u_next, w_scroll_nxt;
  logic [VW-1:0]         w_v_cnt, w_v_next;
  logic [UW1-1:0]        w_scroll_sum;
  logic [ADDR_WIDTH-1:0] w_v_ext, w_row_base, w_addr_next;

  assign w_line_start = pixel_tick && (pixel_x == '0);
  assign w_frame_top  = w_line_start && (pixel_y == '0);

  // Column counter restarts at the scroll offset on every line.
  tile_wrap_counter #(.MOD(TILE_W)) u_ucnt (
    .clk(clk), .reset(reset),
    .load(w_line_start), .load_val(r_scroll_u), .inc(pixel_tick),
    .cnt(w_u_cnt), .cnt_next(w_u_next)
  );

  // Row counter steps once per line and restarts on the top line.
  tile_wrap_counter #(.MOD(TILE_H)) u_vcnt (
    .clk(clk), .reset(reset),
    .load(w_frame_top), .load_val('0), .inc(w_line_start),
    .cnt(w_v_cnt), .cnt_next(w_v_next)
  );

  // Row base = v*TILE_W; the default 20-wide tile uses v*16 + v*4.
  assign w_v_ext = ADDR_WIDTH'(w_v_next);
  if (TILE_W == 20) begin : g_shift
    assign w_row_base = (w_v_ext << 4) + (w_v_ext << 2);
  end else begin : g_mul
    assign w_row_base = w_v_ext * ADDR_WIDTH'(TILE_W);
  end
  assign w_addr_next = w_row_base + ADDR_WIDTH'(w_u_next);

  // Scroll offset wraps modulo TILE_W (SCROLL_STEP < TILE_W, one subtract suffices).
  assign w_scroll_sum = UW1'(r_scroll_u) + UW1'(SCROLL_STEP);
  assign w_scroll_nxt = (w_scroll_sum >= UW1'(TILE_W)) ? UW'(w_scroll_sum - UW1'(TILE_W))
                                                       : UW'(w_scroll_sum);

  // Scroll register; a coincident line-start tick still loads the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         r_scroll_u <= '0;
    else if (frame_start && scroll_en) r_scroll_u <= w_scroll_nxt;
  end

  // Address and stage-1 visibility captured on pixel_tick, held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rom_addr <= '0;
      r_vis_d1   <= 1'b0;
    end else if (pixel_tick) begin
      r_rom_addr <= w_addr_next;
      r_vis_d1   <= video_on;
    end
  end

  // Valid pipeline: [0] marks a fresh address, [1] marks visible ROM data;
  // rgb_valid is a one-cycle pulse per visible tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_pipe  <= '0;
      r_rgb       <= '0;
      r_rgb_valid <= 1'b0;
    end else begin
      r_vld_pipe[0] <= pixel_tick;
      r_vld_pipe[1] <= r_vld_pipe[0] & r_vis_d1;
      r_rgb         <= rom_data;
      r_rgb_valid   <= r_vld_pipe[1];
    end
  end

  assign rom_addr  = r_rom_addr;
  assign rgb_o     = r_rgb;
  assign rgb_valid = r_rgb_valid;
endmodule

// File: tb/tb_floor_addr_gen.sv
// Directed bench for floor_addr_gen: reference u/v/scroll model for addresses,
// scoreboard of expected (due cycle, colour) entries checked by a monitor.
module tb_floor_addr_gen;
  logic        clk = 1'b0;
  logic        reset;
  logic        pixel_tick, video_on, frame_start, scroll_en;
  logic [9:0]  pixel_x, pixel_y;
  logic [19:0] rom_addr;
  logic [11:0] rom_data;
  logic [11:0] rgb_o;
  logic        rgb_valid;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct { int due; floor_pkg::rgb_t rgb; } exp_t;
  exp_t sb[$];

  // reference model state
  int m_u, m_v, m_scroll;

  floor_addr_gen dut (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .frame_start(frame_start), .scroll_en(scroll_en),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .rgb_o(rgb_o), .rgb_valid(rgb_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 1-cycle ROM with ROM[k] = k
  always @(posedge clk) rom_data <= rom_addr[11:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor: rgb_valid must pulse exactly at each due cycle, nowhere else.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        checks++;
        assert (rgb_valid === 1'b1 && rgb_o === sb[0].rgb) else begin
          errors++;
          $error("FAIL rgb_out: observed valid=%0b rgb=%0d expected valid=1 rgb=%0d",
                 rgb_valid, rgb_o, sb[0].rgb);
        end
        void'(sb.pop_front());
      end else begin
        checks++;
        assert (rgb_valid === 1'b0) else begin
          errors++;
          $error("FAIL rgb_idle: observed valid=%0b expected valid=0", rgb_valid);
        end
      end
    end
  end

  function automatic int model_addr();
    return m_v * 20 + m_u;
  endfunction

  // One pixel tick (called at a negedge); returns at the next negedge.
  task automatic do_tick(input int x, input int y, input bit vis, input bit fs = 1'b0);
    int   e;
    logic [31:0] ev;
    if (x == 0) m_u = m_scroll; else m_u = (m_u + 1) % 20;
    if (x == 0) m_v = (y == 0) ? 0 : (m_v + 1) % 20;
    e  = model_addr();
    ev = e;
    if (fs) m_scroll = (m_scroll + 1) % 20;
    pixel_x = 10'(x); pixel_y = 10'(y); video_on = vis;
    frame_start = fs; scroll_en = fs; pixel_tick = 1'b1;
    if (vis) sb.push_back('{due: cyc + 3, rgb: ev[11:0]});
    @(negedge clk);
    pixel_tick = 1'b0; frame_start = 1'b0; scroll_en = 1'b0; video_on = 1'b0;
    chk("addr", 32'(rom_addr), ev);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("addr_hold", 32'(rom_addr), 32'(model_addr()));
    end
  endtask

  task automatic frame_pulse(input bit en);
    frame_start = 1'b1; scroll_en = en;
    @(negedge clk);
    frame_start = 1'b0; scroll_en = 1'b0;
    if (en) m_scroll = (m_scroll + 1) % 20;
  endtask

  initial begin
    reset = 1'b1; pixel_tick = 1'b0; video_on = 1'b0; frame_start = 1'b0;
    scroll_en = 1'b0; pixel_x = '0; pixel_y = '0;
    m_u = 0; m_v = 0; m_scroll = 0;
    #1;
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_rgb", 32'(rgb_o), 0);
    chk("rst_valid", 32'(rgb_valid), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // line sweep y=0, x=0..40
    for (int x = 0; x <= 40; x++) begin
      do_tick(x, 0, 1'b1);
      if (x == 19) chk("sweep_x19", 32'(rom_addr), 19);
      if (x == 20) chk("sweep_x20", 32'(rom_addr), 0);
      if (x == 40) chk("sweep_x40", 32'(rom_addr), 0);
    end

    // row wrap, invisible line-start ticks
    for (int y = 1; y <= 21; y++) begin
      do_tick(0, y, 1'b0);
      if (y == 19) chk("row_y19", 32'(rom_addr), 380);
      if (y == 20) chk("row_y20", 32'(rom_addr), 0);
      if (y == 21) chk("row_y21", 32'(rom_addr), 20);
    end
    for (int x = 1; x <= 5; x++) do_tick(x, 21, 1'b1);
    chk("row_y21_x5", 32'(rom_addr), 25);

    // disabled frame_start must not scroll
    frame_pulse(1'b0);
    // scroll by 3
    repeat (3) frame_pulse(1'b1);
    do_tick(0, 0, 1'b1);
    chk("scroll3_x0", 32'(rom_addr), 3);
    do_tick(1, 0, 1'b1);
    chk("scroll3_x1", 32'(rom_addr), 4);

    // up to 19 pulses, then a pulse coincident with the x=0 tick
    repeat (16) frame_pulse(1'b1);
    do_tick(0, 0, 1'b1, 1'b1);
    chk("scroll_coinc_old", 32'(rom_addr), 19);
    do_tick(0, 0, 1'b1);
    chk("scroll_wrap", 32'(rom_addr), 0);

    // stalled raster: tick every 4th cycle
    for (int x = 1; x <= 8; x++) begin
      do_tick(x, 0, (x % 3) != 0);
      idle(3);
    end
    chk("stall_x8", 32'(rom_addr), 8);

    // reset mid-line
    do_tick(9, 0, 1'b1);
    reset = 1'b1;
    sb.delete();
    #1;
    chk("midrst_addr", 32'(rom_addr), 0);
    chk("midrst_rgb", 32'(rgb_o), 0);
    chk("midrst_valid", 32'(rgb_valid), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_u = 0; m_v = 0; m_scroll = 0;
    do_tick(0, 0, 1'b1);
    chk("post_rst_x0", 32'(rom_addr), 0);
    for (int x = 1; x <= 3; x++) do_tick(x, 0, 1'b1);

    idle(5);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
